mc_memory_responder: RTL
========================

// Module: mc_memory_responder
// PURPOSE
//   Memory-side responder for the multicycle MIPS bus (Adr/memoryWD/MemWrite out, memoryRD in).
//   Unified instruction/data word RAM. Combinational read, synchronous write.
//   Adds a byte-stream program loader that fills RAM after reset, then releases the CPU.
//   Provides one memory-mapped output register and a sticky bus-error flag.
// PARAMETERS
//   DEPTH_WORDS  256            RAM depth in 32-bit words; power of two, >=4; AW=$clog2(DEPTH_WORDS)
//   IO_ADDR      32'hFFFF_FFF0  byte address of the memory-mapped output register
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   Adr          in   32  CPU byte address
//   memoryWD     in   32  CPU write data
//   MemWrite     in   1   CPU write strobe, sampled on clk rising edge
//   memoryRD     out  32  read data to CPU, combinational
//   ld_valid     in   1   loader byte valid
//   ld_byte      in   8   loader byte
//   ld_last      in   1   marks final byte of image; qualified by ld_valid
//   ld_ready     out  1   loader may transfer; byte accepted when ld_valid&&ld_ready
//   cpu_run      out  1   0 holds CPU in reset; top level drives CPU reset from ~cpu_run
//   io_out       out  32  memory-mapped output register
//   io_wr_count  out  16  number of writes to IO_ADDR, saturating
//   bus_err      out  1   sticky error flag
// BEHAVIOUR
//   Reset values: state=LOAD, ld_ready=1, cpu_run=0, io_out=0, io_wr_count=0, bus_err=0.
//   Reset also clears the loader byte_cnt and word_addr. RAM contents are not cleared.
//   FSM LOAD:
//     ld_ready=1.
//     Each accepted byte is packed big-endian: byte_cnt 0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0].
//     On the 4th byte, the word is written to mem[word_addr] in that same cycle.
//     Then word_addr++ and byte_cnt returns to 0.
//     Accepted byte with ld_last=1: the partial word is zero-padded in the missing low bytes.
//     That word is written to mem[word_addr] in the same cycle, then the FSM goes to RUN.
//     On the write of word DEPTH_WORDS-1, the FSM goes to RUN even without ld_last.
//   LOAD->RUN: ld_ready falls and cpu_run rises on the clock edge of the final load write.
//   FSM RUN:
//     ld_ready=0. ld_valid is ignored.
//     RUN is left only by reset. Reset mid-load or mid-run restarts the load at word 0.
//   Read (memoryRD), combinational from Adr:
//     LOAD -> 0.
//     Adr < 4*DEPTH_WORDS -> mem[Adr[AW+1:2]]; Adr[1:0] is ignored on reads.
//     Adr == IO_ADDR -> io_out.
//     Any other address -> 0; bus_err is not set on reads.
//   Write, on a rising edge with MemWrite=1 in RUN:
//     Adr[1:0] != 0 -> write dropped, bus_err<=1.
//     Aligned, in RAM range -> mem[Adr[AW+1:2]]<=memoryWD. New data is visible on memoryRD the next cycle.
//     Aligned, == IO_ADDR -> io_out<=memoryWD; io_wr_count++, holding at 16'hFFFF.
//     Aligned, other address -> write dropped, bus_err<=1.
//   MemWrite in LOAD is ignored and does not set bus_err.
//   bus_err clears only on reset.
//   Read and write to the same address in one cycle: memoryRD shows the old data until the edge.
// TESTING
//   Reset, then 8 bytes 01..08 with ld_last on byte 8 ->
//     mem[0]=32'h01020304, mem[1]=32'h05060708;
//     cpu_run=1 and ld_ready=0 after the 8th-byte edge.
//   5 bytes AA,BB,CC,DD,EE with ld_last on EE -> mem[1]=32'hEE000000; RUN entered.
//   RUN: MemWrite Adr=IO_ADDR WD=32'hCAFEF00D, 3 times ->
//     io_out=32'hCAFEF00D, io_wr_count=3;
//     read at IO_ADDR returns 32'hCAFEF00D.
//   RUN: write Adr=32'h0000_0006 -> bus_err=1, RAM unchanged;
//     write Adr=32'h0001_0000 -> bus_err stays 1;
//     read of the same address -> memoryRD=0.
//   DEPTH_WORDS=4: load 16 bytes with no ld_last -> RUN after the 16th byte; a 17th ld_valid is not accepted.
//   Assert reset after 6 load bytes, then load 4 bytes 11,22,33,44 with ld_last ->
//     mem[0]=32'h11223344; cpu_run 0 until that edge.

Source files
------------

// File: rtl/mc_memory_responder.sv
// Unified word RAM responder for the multicycle MIPS bus, with a
// byte-stream boot loader, one memory-mapped output register and a bus-error flag.
module mc_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] memoryWD,
    input  logic        MemWrite,
    output logic [31:0] memoryRD,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_run,
    output logic [31:0] io_out,
    output logic [15:0] io_wr_count,
    output logic        bus_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic          ld_ready_q, ld_ready_d;
    logic          cpu_run_q, cpu_run_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW-1:0] word_addr_q, word_addr_d;
    logic [31:0]   pack_q, pack_d;
    logic [31:0]   io_out_q, io_out_d;
    logic [15:0]   io_wr_count_q, io_wr_count_d;
    logic          bus_err_q, bus_err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic          ld_fire;
    logic [31:0]   ld_word;
    logic          adr_in_ram;
    logic          adr_is_io;
    logic          adr_aligned;
    logic [AW-1:0] adr_idx;

    assign adr_in_ram  = {1'b0, Adr} < RAM_BYTES;
    assign adr_is_io   = Adr == IO_ADDR;
    assign adr_aligned = Adr[1:0] == 2'b00;
    assign adr_idx     = Adr[AW+1:2];

    assign ld_fire = (state_q == S_LOAD) && ld_valid && ld_ready_q;

    // Big-endian packing: byte n lands at bit 8*(3-n); missing low bytes stay zero.
    assign ld_word = pack_q | ({24'h0, ld_byte} << {~byte_cnt_q, 3'b000});

    always_comb begin
        state_d       = state_q;
        ld_ready_d    = ld_ready_q;
        cpu_run_d     = cpu_run_q;
        byte_cnt_d    = byte_cnt_q;
        word_addr_d   = word_addr_q;
        pack_d        = pack_q;
        io_out_d      = io_out_q;
        io_wr_count_d = io_wr_count_q;
        bus_err_d     = bus_err_q;
        mem_we        = 1'b0;
        mem_waddr     = word_addr_q;
        mem_wdata     = ld_word;

        unique case (state_q)
            S_LOAD: begin
                if (ld_fire) begin
                    if (byte_cnt_q == 2'd3 || ld_last) begin
                        mem_we      = 1'b1;
                        word_addr_d = word_addr_q + AW'(1);
                        byte_cnt_d  = 2'd0;
                        pack_d      = '0;
                        if (ld_last || word_addr_q == LAST_WORD) begin
                            state_d    = S_RUN;
                            ld_ready_d = 1'b0;
                            cpu_run_d  = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        pack_d     = ld_word;
                    end
                end
            end
            S_RUN: begin
                if (MemWrite) begin
                    if (!adr_aligned) begin
                        bus_err_d = 1'b1;
                    end else if (adr_in_ram) begin
                        mem_we    = 1'b1;
                        mem_waddr = adr_idx;
                        mem_wdata = memoryWD;
                    end else if (adr_is_io) begin
                        io_out_d = memoryWD;
                        if (io_wr_count_q != 16'hFFFF) begin
                            io_wr_count_d = io_wr_count_q + 16'd1;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_LOAD;
            ld_ready_q    <= 1'b1;
            cpu_run_q     <= 1'b0;
            byte_cnt_q    <= 2'd0;
            word_addr_q   <= '0;
            pack_q        <= '0;
            io_out_q      <= '0;
            io_wr_count_q <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_ready_q    <= ld_ready_d;
            cpu_run_q     <= cpu_run_d;
            byte_cnt_q    <= byte_cnt_d;
            word_addr_q   <= word_addr_d;
            pack_q        <= pack_d;
            io_out_q      <= io_out_d;
            io_wr_count_q <= io_wr_count_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // RAM keeps its contents across reset so a reload can be partial.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        memoryRD = '0;
        if (state_q == S_RUN) begin
            if (adr_in_ram) begin
                memoryRD = mem[adr_idx];
            end else if (adr_is_io) begin
                memoryRD = io_out_q;
            end
        end
    end

    assign ld_ready    = ld_ready_q;
    assign cpu_run     = cpu_run_q;
    assign io_out      = io_out_q;
    assign io_wr_count = io_wr_count_q;
    assign bus_err     = bus_err_q;

endmodule
